reg_bus_arb: RTL and testbench

REG_BUS_ARB -- requirements
Module: reg_bus_arb

---
 rtl/reg_bus_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 33 +++
 rtl/reg_bus_arb.sv | 150 +++++++++++++++
 tb/tb_reg_bus_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_pkg
// Purpose  : Shared types and constants for the two-requester register-bus
//            arbiter: FSM state encoding, default bus widths, grant-ID type.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package reg_bus_pkg;

  localparam int c_dw_default = 8;
  localparam int c_aw_default = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Grant ID: 0 = requester 0, 1 = requester 1.
  typedef logic gnt_id_t;

  localparam gnt_id_t c_gnt_m0 = 1'b0;
  localparam gnt_id_t c_gnt_m1 = 1'b1;

  function automatic logic [1:0] id_to_onehot(input gnt_id_t id);
    return (id == c_gnt_m1) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin picker, purely combinational.
// Ports    : i_req[1:0]      raw requests
//            i_exclude[1:0]  requesters barred from this pick
//            i_last_grant    ID of the most recent grant
//            o_gnt[1:0]      one-hot grant (zero when nothing eligible)
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2
  import reg_bus_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [1:0] i_exclude,
  input  gnt_id_t    i_last_grant,
  output logic [1:0] o_gnt
);

  logic [1:0] w_elig;

  assign w_elig = i_req & ~i_exclude;

  always_comb begin
    o_gnt = w_elig;
    // On a tie the requester that was not served last wins.
    if (&w_elig) begin
      o_gnt = (i_last_grant == c_gnt_m1) ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_arb
// Purpose  : Arbitrates two register-bus requesters onto one register bus.
//            IDLE -> ACCESS (one strobe cycle) -> RESP (one ack cycle), with
//            re-arbitration at RESP exit for 2-cycle back-to-back throughput.
// Ports    : i_clk, i_rst_n        clock, async active-low reset
//            i_mX_req/wr/addr/wdata requester X command (X = 0,1)
//            o_mX_ack, o_mX_rdata  requester X completion pulse / read data
//            o_wen, o_ren          register bus strobes
//            o_addr, o_wdata       register bus address / write data
//            i_rdata               OR of register-slice read data
//            o_busy                high whenever not IDLE
// Revision : 1.0  initial release
// ============================================================================
module reg_bus_arb
  import reg_bus_pkg::*;
#(
  parameter int DW = c_dw_default,
  parameter int AW = c_aw_default
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_m0_req,
  input  logic          i_m0_wr,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_wdata,
  output logic          o_m0_ack,
  output logic [DW-1:0] o_m0_rdata,
  input  logic          i_m1_req,
  input  logic          i_m1_wr,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_wdata,
  output logic          o_m1_ack,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_wen,
  output logic          o_ren,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  input  logic [DW-1:0] i_rdata,
  output logic          o_busy
);

  state_t  r_state;
  state_t  w_state_nxt;
  // Holds both the ID of the transaction in flight and the round-robin
  // history: every grant updates it, so the two are always equal.
  gnt_id_t r_last_grant;

  logic [1:0]    w_req;
  logic [1:0]    w_excl;
  logic [1:0]    w_gnt;
  logic          w_grant_now;
  gnt_id_t       w_sel_id;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_in_access;

  assign w_req       = {i_m1_req, i_m0_req};
  // Only the RESP exit excludes the requester currently being acked.
  assign w_excl      = (r_state == ST_RESP) ? id_to_onehot(r_last_grant) : 2'b00;
  assign w_in_access = (r_state == ST_ACCESS);

  rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_exclude    (w_excl),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  assign w_sel_id    = gnt_id_t'(w_gnt[1]);
  assign w_sel_wr    = w_gnt[1] ? i_m1_wr    : i_m0_wr;
  assign w_sel_addr  = w_gnt[1] ? i_m1_addr  : i_m0_addr;
  assign w_sel_wdata = w_gnt[1] ? i_m1_wdata : i_m0_wdata;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_now = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_gnt) begin
          w_state_nxt = ST_ACCESS;
          w_grant_now = 1'b1;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (|w_gnt) begin
          w_state_nxt = ST_ACCESS;
          w_grant_now = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs: strobes are loaded on the grant edge so they are
  // high exactly in the ACCESS cycle; acks are loaded on the ACCESS exit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= c_gnt_m1;
      o_busy       <= 1'b0;
      o_wen        <= 1'b0;
      o_ren        <= 1'b0;
      o_m0_ack     <= 1'b0;
      o_m1_ack     <= 1'b0;
      o_addr       <= '0;
      o_wdata      <= '0;
      o_m0_rdata   <= '0;
      o_m1_rdata   <= '0;
    end else begin
      o_busy   <= (w_state_nxt != ST_IDLE);
      o_wen    <= w_grant_now &  w_sel_wr;
      o_ren    <= w_grant_now & ~w_sel_wr;
      o_m0_ack <= w_in_access & (r_last_grant == c_gnt_m0);
      o_m1_ack <= w_in_access & (r_last_grant == c_gnt_m1);
      if (w_grant_now) begin
        r_last_grant <= w_sel_id;
        o_addr       <= w_sel_addr;
        o_wdata      <= w_sel_wdata;
      end
      // o_ren is high only during ACCESS, so it also qualifies the capture.
      if (o_ren && (r_last_grant == c_gnt_m0)) begin
        o_m0_rdata <= i_rdata;
      end
      if (o_ren && (r_last_grant == c_gnt_m1)) begin
        o_m1_rdata <= i_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bus_arb
// Purpose  : Directed self-checking bench for reg_bus_arb.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_bus_arb;

  logic       clk;
  logic       rst_n;
  logic       m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_ack, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic       wen, ren, busy;
  logic [7:0] addr, wdata, rdata;
  logic [4:0] flags;

  int n_total = 0;
  int n_pass  = 0;

  reg_bus_arb #(.DW(8), .AW(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_m0_req   (m0_req),
    .i_m0_wr    (m0_wr),
    .i_m0_addr  (m0_addr),
    .i_m0_wdata (m0_wdata),
    .o_m0_ack   (m0_ack),
    .o_m0_rdata (m0_rdata),
    .i_m1_req   (m1_req),
    .i_m1_wr    (m1_wr),
    .i_m1_addr  (m1_addr),
    .i_m1_wdata (m1_wdata),
    .o_m1_ack   (m1_ack),
    .o_m1_rdata (m1_rdata),
    .o_wen      (wen),
    .o_ren      (ren),
    .o_addr     (addr),
    .o_wdata    (wdata),
    .i_rdata    (rdata),
    .o_busy     (busy)
  );

  // {busy, wen, ren, ack0, ack1}
  assign flags = {busy, wen, ren, m0_ack, m1_ack};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_m0(input logic req, input logic wr, input logic [7:0] a, input logic [7:0] d);
    m0_req = req; m0_wr = wr; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drv_m1(input logic req, input logic wr, input logic [7:0] a, input logic [7:0] d);
    m1_req = req; m1_wr = wr; m1_addr = a; m1_wdata = d;
  endtask

  initial begin
    logic exp_m1;
    rst_n = 1'b0;
    rdata = 8'h00;
    drv_m0(1'b0, 1'b0, 8'h00, 8'h00);
    drv_m1(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset state
    tick(); tick();
    chk("rst_flags", 16'(flags), 16'h00);
    chk("rst_addr",  16'(addr),  16'h00);
    chk("rst_wdata", 16'(wdata), 16'h00);
    chk("rst_rd0",   16'(m0_rdata), 16'h00);
    chk("rst_rd1",   16'(m1_rdata), 16'h00);
    rst_n = 1'b1;
    tick();
    chk("idle_flags", 16'(flags), 16'h00);

    // Single write from m0
    drv_m0(1'b1, 1'b1, 8'h12, 8'hA5);
    tick();
    chk("wr_access_flags", 16'(flags), 16'b11000);
    chk("wr_addr",  16'(addr),  16'h12);
    chk("wr_wdata", 16'(wdata), 16'hA5);
    tick();
    chk("wr_resp_flags", 16'(flags), 16'b10010);
    drv_m0(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("wr_idle_flags", 16'(flags), 16'h00);
    chk("wr_addr_hold",  16'(addr),  16'h12);

    // Single read from m1
    rdata = 8'h3C;
    drv_m1(1'b1, 1'b0, 8'h05, 8'h77);
    tick();
    chk("rd_access_flags", 16'(flags), 16'b10100);
    chk("rd_addr",  16'(addr), 16'h05);
    tick();
    chk("rd_resp_flags", 16'(flags), 16'b10001);
    chk("rd_rdata1", 16'(m1_rdata), 16'h3C);
    chk("rd_rdata0", 16'(m0_rdata), 16'h00);
    drv_m1(1'b0, 1'b0, 8'h00, 8'h00);
    rdata = 8'h00;
    tick();
    chk("rd_idle_flags", 16'(flags), 16'h00);
    chk("rd_rdata1_hold", 16'(m1_rdata), 16'h3C);

    // Contention: last grant was m1, so m0 first, then m1 back-to-back
    drv_m0(1'b1, 1'b1, 8'h20, 8'h11);
    drv_m1(1'b1, 1'b1, 8'h21, 8'h22);
    tick();
    chk("c1_acc0_flags", 16'(flags), 16'b11000);
    chk("c1_acc0_addr",  16'(addr),  16'h20);
    tick();
    chk("c1_resp0_flags", 16'(flags), 16'b10010);
    drv_m0(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("c1_acc1_flags", 16'(flags), 16'b11000);
    chk("c1_acc1_addr",  16'(addr),  16'h21);
    chk("c1_acc1_wdata", 16'(wdata), 16'h22);
    tick();
    chk("c1_resp1_flags", 16'(flags), 16'b10001);
    drv_m1(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("c1_idle_flags", 16'(flags), 16'h00);

    // Solo m0 read leaves m0 as last grant
    rdata = 8'h5A;
    drv_m0(1'b1, 1'b0, 8'h30, 8'h00);
    tick();
    chk("s0_access_flags", 16'(flags), 16'b10100);
    tick();
    chk("s0_resp_flags", 16'(flags), 16'b10010);
    chk("s0_rdata0", 16'(m0_rdata), 16'h5A);
    chk("s0_rdata1", 16'(m1_rdata), 16'h3C);
    drv_m0(1'b0, 1'b0, 8'h00, 8'h00);
    rdata = 8'h00;
    tick();

    // Repeat contention: m1 wins now
    drv_m0(1'b1, 1'b1, 8'h40, 8'h01);
    drv_m1(1'b1, 1'b1, 8'h41, 8'h02);
    tick();
    chk("c2_acc_first_addr", 16'(addr), 16'h41);
    tick();
    chk("c2_resp_first_flags", 16'(flags), 16'b10001);
    drv_m1(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("c2_acc_second_addr", 16'(addr), 16'h40);
    tick();
    chk("c2_resp_second_flags", 16'(flags), 16'b10010);
    drv_m0(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("c2_idle_flags", 16'(flags), 16'h00);

    // Continuous back-to-back: 10 alternating transactions, m1 first
    drv_m0(1'b1, 1'b1, 8'h50, 8'h0A);
    drv_m1(1'b1, 1'b1, 8'h51, 8'h0B);
    exp_m1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("b2b_access_flags", 16'(flags), 16'b11000);
      chk("b2b_addr", 16'(addr), exp_m1 ? 16'h51 : 16'h50);
      tick();
      chk("b2b_resp_flags", 16'(flags), exp_m1 ? 16'b10001 : 16'b10010);
      if (i == 9) begin
        drv_m0(1'b0, 1'b0, 8'h00, 8'h00);
        drv_m1(1'b0, 1'b0, 8'h00, 8'h00);
      end
      exp_m1 = ~exp_m1;
    end
    tick();
    chk("b2b_idle_flags", 16'(flags), 16'h00);

    // Withdrawn request: m1 pulses req only during m0's ACCESS
    drv_m0(1'b1, 1'b1, 8'h60, 8'h66);
    tick();
    chk("wd_access_addr", 16'(addr), 16'h60);
    drv_m1(1'b1, 1'b1, 8'h61, 8'h99);
    tick();
    chk("wd_resp_flags", 16'(flags), 16'b10010);
    drv_m1(1'b0, 1'b0, 8'h00, 8'h00);
    drv_m0(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("wd_idle_flags", 16'(flags), 16'h00);
    tick();
    chk("wd_still_idle_flags", 16'(flags), 16'h00);
    chk("wd_addr_hold", 16'(addr), 16'h60);

    // Reset mid-transaction: m1 then m0 served -> last grant m0 before reset
    drv_m0(1'b1, 1'b1, 8'h70, 8'h33);
    tick();
    chk("mr_access_flags", 16'(flags), 16'b11000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_flags", 16'(flags), 16'h00);
    chk("mr_async_addr",  16'(addr),  16'h00);
    chk("mr_async_wdata", 16'(wdata), 16'h00);
    chk("mr_async_rd0",   16'(m0_rdata), 16'h00);
    chk("mr_async_rd1",   16'(m1_rdata), 16'h00);
    drv_m0(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_no_ack_flags", 16'(flags), 16'h00);
    drv_m0(1'b1, 1'b1, 8'h80, 8'h44);
    drv_m1(1'b1, 1'b1, 8'h81, 8'h55);
    tick();
    chk("mr_cont_addr", 16'(addr), 16'h80);
    tick();
    chk("mr_cont_resp_flags", 16'(flags), 16'b10010);
    drv_m0(1'b0, 1'b0, 8'h00, 8'h00);
    drv_m1(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("mr_final_idle_flags", 16'(flags), 16'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
